fma16_arb: RTL
==============

# fma16_arb

Round-robin arbiter and result sequencer that shares one fixed-latency `fma16` datapath (operand alignment, multiply, add, normalize, round) between `NREQ` requesters. It grants at most one operation per cycle, drives the shared unit's operand and control inputs, and tracks each in-flight operation's requester ID through the unit's latency. Results land in a credit-protected FIFO so requesters may backpressure responses without stalling the datapath. Sits between the issue logic of the FP clients and the single `fma16` instance.

## Interface
- `NREQ`, 2: number of requesters (2..4).
- `LAT`, 2: cycles from `fma_issue` to valid `fma_result` (≥1). Result FIFO depth is fixed at `DEPTH = LAT+1`.
- `clk` input 1: clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: request pending, one bit per requester.
- `req_ready` output NREQ: one-hot grant; request i accepted when `req_valid[i] & req_ready[i]`.
- `req_x`, `req_y`, `req_z` input 16*NREQ: packed half-precision operands, slice i belongs to requester i.
- `req_ctrl` input 6*NREQ: per requester {mul, add, negp, negz, roundmode[1:0]}.
- `fma_issue` output 1: operation launched into the shared unit this cycle.
- `fma_x`, `fma_y`, `fma_z` output 16: operands of the granted requester, 0 when not issuing.
- `fma_ctrl` output 6: control of the granted requester, 0 when not issuing.
- `fma_result` input 16: unit result, valid exactly `LAT` cycles after `fma_issue`.
- `fma_flags` input 4: {invalid, overflow, underflow, inexact}, same timing as `fma_result`.
- `rsp_valid` output 1: FIFO head valid.
- `rsp_ready` input 1: consumer accepts head.
- `rsp_id` output $clog2(NREQ): requester that issued the head operation.
- `rsp_result` output 16, `rsp_flags` output 4: head payload.

## Operation
- Credit counter `outst` (0..DEPTH) = in-flight ops + FIFO occupancy. `outst` increments on issue, decrements on pop (`rsp_valid & rsp_ready`). Simultaneous issue and pop leaves it unchanged.
- Issue allowed only when `outst < DEPTH`. This guarantees the FIFO never overflows.
- Grant: among asserted `req_valid`, pick the first at or after pointer `rr`, in modulo-NREQ order. When allowed and any request is valid, set the winner's `req_ready` and `fma_issue`. `req_ready` is combinational from `req_valid`, `rr` and `outst`; it is never asserted for a non-valid requester.
- `rr` updates to (winner+1) mod NREQ on issue and holds otherwise.
- Tag pipeline: LAT-stage shift register of {valid, id}, loaded on issue. When stage LAT is valid, push {id, `fma_result`, `fma_flags`} into the FIFO.
- FIFO: circular, DEPTH entries, read and write pointers wrap at DEPTH. Push and pop in the same cycle are legal, including when the FIFO holds one entry or is full at DEPTH.
- FIFO empty → `rsp_valid`=0 and `rsp_id`/`rsp_result`/`rsp_flags`=0. The head is stable while `rsp_valid & ~rsp_ready`.
- No requests valid, or `outst == DEPTH` → no grant, `fma_issue`=0, `rr` holds.

## Timing
- Reset (async assert, sync release): `req_ready`=0, `fma_issue`=0, `fma_*`=0, `rsp_valid`=0, `rsp_*`=0, `rr`=0, `outst`=0, tag pipeline and FIFO cleared. Reset mid-operation discards all in-flight and buffered ops. `fma_result` values from pre-reset issues are never pushed.
- Grant is same-cycle combinational (cycle T). The result enters the FIFO at the edge ending cycle T+LAT. Earliest `rsp_valid` is cycle T+LAT+1.
- Throughput: one issue per cycle sustained while `rsp_ready`=1. Each credit is held from T+1 through the pop cycle.
- Responses return in issue order across all requesters.

## Test plan
- Single request, NREQ=2, LAT=2: requester 0 sends x=0x3C00, y=0x4000, z=0x3C00, ctrl add+mul, issued in cycle 0. Expect `fma_issue` in cycle 0 and `rsp_valid` in cycle 3 with `rsp_id`=0, `rsp_result`=0x4200.
- Round-robin: both requesters hold `req_valid`=1 continuously. Expect grants 0,1,0,1,… with no bubbles, and `rsp_id` sequence 0,1,0,1,… starting at cycle 3.
- Backpressure: `rsp_ready`=0 while both requesters are valid. Expect exactly 3 issues (DEPTH) followed by `req_ready`=0. Raise `rsp_ready`: 3 responses pop in order, and issue resumes in the cycle after the first pop.
- Simultaneous push/pop at full and wrap: run `rsp_ready` in a 1-of-2 pattern for 20 ops. Expect no loss, no duplication, and correct order across pointer wrap.
- Reset mid-flight: assert `reset_n`=0 one cycle after issue. Expect all outputs 0 immediately. After release with no new requests, `rsp_valid` stays 0 for 5 cycles.
- Idle/non-valid: `req_valid`=0 for 10 cycles. Expect `fma_issue`=0, `fma_x`=0, and `rr` unchanged, so the next grant goes to the pointer's requester.

Source files
------------

// File: rtl/fma16_arb.sv
// rtl/fma16_arb.sv - round-robin arbiter and in-order result sequencer for a shared fma16 unit
module fma16_arb #(
    parameter int NREQ = 2,
    parameter int LAT  = 2,
    localparam int DEPTH = LAT + 1,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    input  logic [16*NREQ-1:0]   req_z,
    input  logic [6*NREQ-1:0]    req_ctrl,
    output logic                 fma_issue,
    output logic [15:0]          fma_x,
    output logic [15:0]          fma_y,
    output logic [15:0]          fma_z,
    output logic [5:0]           fma_ctrl,
    input  logic [15:0]          fma_result,
    input  logic [3:0]           fma_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_result,
    output logic [3:0]           rsp_flags
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Arbitration state: rotating priority pointer and credit counter.
    logic [IDW-1:0] rr;
    logic [IDW-1:0] win;
    logic [IDW:0]   cand;
    logic           any_valid;
    logic           can_issue;
    logic [CW-1:0]  outst;

    // Tag pipeline mirrors the datapath latency so each result knows its owner.
    logic           tag_v  [1:LAT];
    logic [IDW-1:0] tag_id [1:LAT];

    // Result FIFO storage and pointers.
    logic [IDW-1:0] mem_id     [DEPTH];
    logic [15:0]    mem_result [DEPTH];
    logic [3:0]     mem_flags  [DEPTH];
    logic [PW-1:0]  wp;
    logic [PW-1:0]  rp;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // First valid requester at or after rr, wrapping modulo NREQ.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr} + (IDW + 1)'(k);
            if (cand >= (IDW + 1)'(NREQ)) begin
                cand = cand - (IDW + 1)'(NREQ);
            end
            if (!any_valid && req_valid[cand[IDW-1:0]]) begin
                any_valid = 1'b1;
                win       = cand[IDW-1:0];
            end
        end
    end

    // A credit must be free; reset also blocks the grant since it is combinational.
    assign can_issue = reset_n && (outst < CW'(DEPTH));
    assign fma_issue = can_issue && any_valid;

    // One-hot grant to the winner only when an operation is launched.
    always_comb begin
        req_ready = '0;
        if (fma_issue) begin
            req_ready[win] = 1'b1;
        end
    end

    // Steer the granted requester's operands to the shared unit, zero otherwise.
    always_comb begin
        fma_x    = '0;
        fma_y    = '0;
        fma_z    = '0;
        fma_ctrl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                fma_x    = req_x[i*16 +: 16];
                fma_y    = req_y[i*16 +: 16];
                fma_z    = req_z[i*16 +: 16];
                fma_ctrl = req_ctrl[i*6 +: 6];
            end
        end
    end

    assign push = tag_v[LAT];
    assign pop  = rsp_valid && rsp_ready;

    // Pointer advances past the winner; credits count in-flight plus buffered ops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr    <= '0;
            outst <= '0;
        end else begin
            if (fma_issue) begin
                rr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
            case ({fma_issue, pop})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: outst <= outst;
            endcase
        end
    end

    // Shift the requester tag alongside the operation through the unit's latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= LAT; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[1]  <= fma_issue;
            tag_id[1] <= win;
            for (int k = 2; k <= LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    // Capture the tagged result when it emerges from the unit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < DEPTH; d++) begin
                mem_id[d]     <= '0;
                mem_result[d] <= '0;
                mem_flags[d]  <= '0;
            end
        end else if (push) begin
            mem_id[wp]     <= tag_id[LAT];
            mem_result[wp] <= fma_result;
            mem_flags[wp]  <= fma_flags;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave occupancy unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= ptr_inc(wp);
            end
            if (pop) begin
                rp <= ptr_inc(rp);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rsp_valid  = (count != '0);
    assign rsp_id     = rsp_valid ? mem_id[rp]     : '0;
    assign rsp_result = rsp_valid ? mem_result[rp] : '0;
    assign rsp_flags  = rsp_valid ? mem_flags[rp]  : '0;

endmodule
